// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU bus shared between fetch, the issue controller and the ALU.
// The slave modport is the controller's view; master is the environment (fetch + ALU).
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [3:0]        codop;
  logic [DATA_W-1:0] operando1;
  logic [DATA_W-1:0] operando2;
  logic [DATA_W-1:0] resultado;
  logic              neg;
  logic              zero;
  logic              overflow;

  modport slave (
    input  instr_valid, instr, resultado, neg, zero, overflow,
    output instr_ready, codop, operando1, operando2
  );

  modport master (
    output instr_valid, instr, resultado, neg, zero, overflow,
    input  instr_ready, codop, operando1, operando2
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back sequencer for the 16-bit ALU: accepts one instruction, reads the register
// file, drives the ALU for a cycle, then writes back result, status flags and branch outcome.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int IMM_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_ctrl_if.slave   bus,
  output logic              done,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              illegal,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  state_e            state_q, state_d;
  logic [15:0]       instr_q;
  logic [3:0]        codop_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              done_q, illegal_q, br_taken_q;
  logic [DATA_W-1:0] br_target_q;
  logic              flag_n_q, flag_z_q, flag_v_q;

  logic              ready_c, ld_instr, ld_ops, wb;

  logic [2:0]        rd, rs, rt;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_sext;
  logic              imm_op;

  assign rd       = instr_q[11:9];
  assign rs       = instr_q[8:6];
  assign rt       = instr_q[5:3];
  assign imm      = instr_q[IMM_W-1:0];
  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_op   = (instr_q[15:12] >= 4'd6) && (instr_q[15:12] <= 4'd10);

  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    ld_instr = 1'b0;
    ld_ops   = 1'b0;
    wb       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) begin
          ld_instr = 1'b1;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        ld_ops  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_WB;
      S_WB: begin
        wb      = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      codop_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= wb;
      illegal_q  <= wb && (codop_q >= 4'd13);
      br_taken_q <= wb && (codop_q == 4'd12) && (op1_q == '0);
      if (ld_instr) instr_q <= bus.instr;
      // ALU inputs change only here, so they stay stable through EXEC/WB and afterwards
      if (ld_ops) begin
        codop_q <= instr_q[15:12];
        op1_q   <= regs_q[rs];
        op2_q   <= imm_op ? imm_sext : regs_q[rt];
      end
      if (wb) begin
        if (codop_q <= 4'd11) regs_q[rd] <= bus.resultado;
        if (codop_q == 4'd0 || codop_q == 4'd1 || codop_q == 4'd9 || codop_q == 4'd10) begin
          flag_n_q <= bus.neg;
          flag_v_q <= bus.overflow;
        end
        if (codop_q == 4'd12) begin
          flag_z_q <= bus.zero;
          if (op1_q == '0) br_target_q <= op2_q;
        end
      end
    end
  end

  assign bus.instr_ready = ready_c;
  assign bus.codop       = codop_q;
  assign bus.operando1   = op1_q;
  assign bus.operando2   = op2_q;
  assign done            = done_q;
  assign illegal         = illegal_q;
  assign branch_taken    = br_taken_q;
  assign branch_target   = br_target_q;
  assign flag_n          = flag_n_q;
  assign flag_z          = flag_z_q;
  assign flag_v          = flag_v_q;
  assign dbg_data        = regs_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: small ALU stand-in, instruction-level reference model,
// directed scenarios followed by randomized instruction streams.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        done, flag_n, flag_z, flag_v, branch_taken, illegal;
  logic [15:0] branch_target, dbg_data;
  logic [2:0]  dbg_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mregs [8];
  logic        mn, mz, mv;

  alu_issue_ctrl_if #(.DATA_W(16)) bus ();

  alu_issue_ctrl #(.DATA_W(16), .NREGS(8), .IMM_W(6)) dut (
    .clk(clk), .reset(reset), .bus(bus), .done(done),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // ALU stand-in: 0/9 add, 1 sub, 10 reverse sub, 2 unsigned less-than, 3 shl, 4 shr,
  // 5/7 xor, 6 and, 8 or, 11/12 pass operando1, others a fixed pattern
  logic [15:0] alu_a, alu_b, alu_r;
  logic        alu_v;
  always_comb begin
    alu_a = bus.operando1;
    alu_b = bus.operando2;
    alu_r = 16'h0;
    alu_v = 1'b0;
    case (bus.codop)
      4'd0, 4'd9: begin alu_r = alu_a + alu_b; alu_v = (alu_a[15] == alu_b[15]) && (alu_r[15] != alu_a[15]); end
      4'd1:  begin alu_r = alu_a - alu_b; alu_v = (alu_a[15] != alu_b[15]) && (alu_r[15] != alu_a[15]); end
      4'd10: begin alu_r = alu_b - alu_a; alu_v = (alu_b[15] != alu_a[15]) && (alu_r[15] != alu_b[15]); end
      4'd2:  alu_r = {15'h0, alu_a < alu_b};
      4'd3:  alu_r = alu_a << alu_b[3:0];
      4'd4:  alu_r = alu_a >> alu_b[3:0];
      4'd5, 4'd7: alu_r = alu_a ^ alu_b;
      4'd6:  alu_r = alu_a & alu_b;
      4'd8:  alu_r = alu_a | alu_b;
      4'd11, 4'd12: alu_r = alu_a;
      default: alu_r = 16'h5A5A;
    endcase
    bus.resultado = alu_r;
    bus.neg       = alu_r[15];
    bus.zero      = (alu_r == 16'h0);
    bus.overflow  = alu_v;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int rt);
    logic [3:0] o; logic [2:0] d, s, t;
    o = 4'(op); d = 3'(rd); s = 3'(rs); t = 3'(rt);
    return {o, d, s, t, 3'b000};
  endfunction

  function automatic logic [15:0] enci(input int op, input int rd, input int rs, input int imm);
    logic [3:0] o; logic [2:0] d, s; logic [5:0] i;
    o = 4'(op); d = 3'(rd); s = 3'(rs); i = 6'(imm);
    return {o, d, s, i};
  endfunction

  // Architectural effect of one instruction, from the instruction-set rules
  task automatic model_exec(input logic [15:0] ins, output logic eb, output logic [15:0] et,
                            output logic eill);
    int op, sa, sb, simm, full;
    logic [15:0] a, b, res;
    logic fl;
    op   = int'(ins[15:12]);
    simm = $signed(ins[5:0]);
    a    = mregs[ins[8:6]];
    b    = (op >= 6 && op <= 10) ? 16'(simm) : mregs[ins[5:3]];
    sa   = $signed(a);
    sb   = $signed(b);
    eb = 1'b0; et = 16'h0; eill = (op >= 13); fl = 1'b0; res = 16'h0; full = 0;
    case (op)
      0, 9: begin full = sa + sb; fl = 1'b1; end
      1:    begin full = sa - sb; fl = 1'b1; end
      10:   begin full = sb - sa; fl = 1'b1; end
      2:    res = (a < b) ? 16'd1 : 16'd0;
      3:    res = a << b[3:0];
      4:    res = a >> b[3:0];
      5, 7: res = a ^ b;
      6:    res = a & b;
      8:    res = a | b;
      11:   res = a;
      12: begin
        mz = (a == 16'h0);
        eb = (a == 16'h0);
        if (eb) et = b;
      end
      default: ;
    endcase
    if (fl) begin
      res = 16'(full);
      mn  = res[15];
      mv  = (full > 32767) || (full < -32768);
    end
    if (op <= 11) mregs[ins[11:9]] = res;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mn = 1'b0; mz = 1'b0; mv = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s_R%0d", tag, i), dbg_data, mregs[i]);
    end
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_n"}, flag_n, mn);
    chk({tag, "_z"}, flag_z, mz);
    chk({tag, "_v"}, flag_v, mv);
  endtask

  task automatic issue(input logic [15:0] ins);
    int w;
    logic eb, eill;
    logic [15:0] et;
    w = 0;
    while (!bus.instr_ready && w < 10) begin step(); w++; end
    chk("ready_idle", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    step();
    bus.instr = 16'($urandom);
    model_exec(ins, eb, et, eill);
    chk("ready_busy", bus.instr_ready, 0);
    w = 0;
    while (!done && w < 8) begin
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.instr       = 16'($urandom);
      step();
      w++;
    end
    bus.instr_valid = 1'b0;
    chk("latency", w, 3);
    chk("illegal", illegal, eill);
    chk("br_taken", branch_taken, eb);
    if (eb) chk("br_target", branch_target, et);
    chk("ready_done", bus.instr_ready, 1);
    check_flags("flag");
    check_regs("wb");
  endtask

  logic [15:0] b2b [4];

  initial begin
    int cyc, last, idx;
    logic eb, eill, pre;
    logic [15:0] et;
    reset = 1'b1; bus.instr_valid = 1'b0; bus.instr = 16'h0; dbg_addr = 3'd0;
    model_reset();
    step(); step();
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_codop", bus.codop, 0);
    chk("rst_op1", bus.operando1, 0);
    chk("rst_op2", bus.operando2, 0);
    chk("rst_br", {branch_taken, branch_target, illegal}, 0);
    check_flags("rst_flag");
    check_regs("rst");
    reset = 1'b0;

    // R1=0x7FFF, R2=1, then add into R3
    issue(enci(8, 1, 0, 6'h3F));
    issue(enci(8, 7, 0, 1));
    issue(enc(4, 1, 1, 7));
    issue(enci(8, 2, 0, 1));
    issue(enc(0, 3, 1, 2));
    dbg_addr = 3'd3; #1;
    chk("ovf_sum", dbg_data, 16'h8000);
    chk("ovf_flags", {flag_n, flag_v}, 2'b11);

    // R1=5; R4 = R1 + sext(0x3F)
    issue(enci(6, 1, 0, 0));
    issue(enci(8, 1, 0, 5));
    issue(enci(9, 4, 1, 6'h3F));
    dbg_addr = 3'd4; #1;
    chk("addi_neg", dbg_data, 16'h0004);
    chk("addi_flags", {flag_n, flag_v}, 2'b00);

    // R1=0, R2=0x40; branch on R1==0
    issue(enci(6, 1, 0, 0));
    issue(enci(8, 6, 0, 6));
    issue(enci(8, 2, 0, 1));
    issue(enc(3, 2, 2, 6));
    issue(enc(12, 0, 1, 2));
    chk("branch_tgt_const", branch_target, 16'h0040);
    chk("branch_z", flag_z, 1);
    issue(enc(14, 3, 1, 2));
    issue(enc(2, 5, 2, 1));
    issue(enc(10, 3, 2, 2));

    // Reset while an add is in EXEC: no write, no done
    issue(enci(8, 1, 0, 3));
    bus.instr_valid = 1'b1; bus.instr = enc(0, 5, 1, 1);
    step();
    bus.instr_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    chk("midrst_ready", bus.instr_ready, 1);
    chk("midrst_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_nodone", done, 0);
    end
    check_flags("midrst_flag");
    check_regs("midrst");

    // Back-to-back accepts with valid held high
    issue(enci(8, 1, 0, 3));
    issue(enci(8, 2, 0, 6'h3E));
    b2b[0] = enc(0, 3, 1, 2);
    b2b[1] = enc(1, 4, 3, 1);
    b2b[2] = enc(5, 5, 4, 2);
    b2b[3] = enci(9, 6, 5, 7);
    idx = 0; last = -100; cyc = 0;
    bus.instr_valid = 1'b1; bus.instr = b2b[0];
    for (int k = 0; k < 24; k++) begin
      pre = bus.instr_ready && bus.instr_valid;
      step();
      cyc++;
      if (pre && idx < 4) begin
        if (idx > 0) chk("b2b_spacing", cyc - last, 4);
        last = cyc;
        model_exec(b2b[idx], eb, et, eill);
        idx++;
        if (idx == 4) bus.instr_valid = 1'b0;
        else bus.instr = b2b[idx];
      end
      chk("b2b_done", done, (cyc == last + 3) ? 1 : 0);
    end
    chk("b2b_count", idx, 4);
    check_flags("b2b_flag");
    check_regs("b2b");

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) issue(16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
